// File: rtl/record_play_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// record_play_ctrl_pkg
//   Shared constants for the record/playback sequencer:
//   - AW, DW      : default RAM address width and note word width
//   - MAX_NOTES   : capacity of the note RAM (2^AW)
//   - ST_*        : FSM state encodings, also shown on the LED display
// ---------------------------------------------------------------------------
package record_play_ctrl_pkg;

  localparam int AW        = 6;
  localparam int DW        = 32;
  localparam int MAX_NOTES = 64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_RECORD = 3'd2;
  localparam logic [2:0] ST_PLAY   = 3'd3;
  localparam logic [2:0] ST_PFETCH = 3'd4;

endpackage

// File: rtl/note_accum.sv
// ---------------------------------------------------------------------------
// note_accum
//   Sticky OR accumulator: every bit seen on din since the last clear stays
//   set, so a short key press anywhere inside a beat is still recorded.
//   Ports:
//     clk    in   system clock
//     reset  in   synchronous active-high reset
//     clear  in   zero the accumulator on the next edge (wins over din)
//     din    in   live note vector
//     acc    out  accumulated note vector
// ---------------------------------------------------------------------------
module note_accum #(
  parameter int DW = record_play_ctrl_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;

  always_comb begin
    acc_d = clear ? '0 : (acc_q | din);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/record_play_ctrl.sv
// ---------------------------------------------------------------------------
// record_play_ctrl
//   Beat-synchronous note recorder / player driving an external synchronous
//   RAM (read data valid one cycle after the address).
//   Record: after arming, each beat writes the OR of all notes seen during
//   that beat to the next RAM address, up to 2^AW notes.
//   Play: each beat fetches the next stored note; note_out updates and
//   note_valid pulses two cycles after the beat.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     beat_tick            beat boundary pulse
//     select, back         start/stop and abort command pulses
//     mode_rec             1 = record, 0 = play (used only in IDLE)
//     loop                 wrap playback to the first note
//     note_in              live note vector
//     ram_rdata            RAM read data
//     ram_addr/wren/wdata  RAM address, write strobe, write data
//     note_out/note_valid  played note and its update pulse
//     length               number of stored notes (0..2^AW)
//     state                FSM state for the LED display
// ---------------------------------------------------------------------------
module record_play_ctrl #(
  parameter int AW = record_play_ctrl_pkg::AW,
  parameter int DW = record_play_ctrl_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          beat_tick,
  input  logic          select,
  input  logic          back,
  input  logic          mode_rec,
  input  logic          loop,
  input  logic [DW-1:0] note_in,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wren,
  output logic [DW-1:0] ram_wdata,
  output logic [DW-1:0] note_out,
  output logic          note_valid,
  output logic [AW:0]   length,
  output logic [2:0]    state
);

  import record_play_ctrl_pkg::*;

  localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};
  localparam logic [AW:0]   FULL_LEN = {1'b1, {AW{1'b0}}};

  logic [2:0]    state_q,      state_d;
  logic [AW-1:0] ptr_q,        ptr_d;
  logic [AW:0]   length_q,     length_d;
  logic [DW-1:0] note_out_q,   note_out_d;
  logic          note_valid_q, note_valid_d;

  logic [DW-1:0] acc;
  logic          acc_clear;
  logic          rec_active;
  logic          is_last_note;

  // The accumulator only collects while recording; the beat that stores a
  // note also restarts collection for the next beat.
  assign acc_clear = (state_q != ST_RECORD) | beat_tick;

  note_accum #(.DW(DW)) u_note_accum (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .din   (note_in),
    .acc   (acc)
  );

  // The RAM port is combinational from the current pointer so the RAM sees
  // the address in the beat cycle itself; reset forces it quiet immediately.
  assign rec_active = (state_q == ST_RECORD) & ~reset;
  assign ram_wren   = rec_active & beat_tick & ~select & ~back;
  assign ram_wdata  = rec_active ? (acc | note_in) : '0;
  assign ram_addr   = reset ? '0 : ptr_q;

  assign is_last_note = ({1'b0, ptr_q} == (length_q - (AW+1)'(1)));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    length_d     = length_q;
    note_out_d   = note_out_q;
    note_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // beat_tick is ignored here; back has nothing to abort.
        if (!back && select) begin
          if (mode_rec) begin
            state_d = ST_ARMED;
          end else if (length_q != '0) begin
            state_d = ST_PLAY;
            ptr_d   = '0;
          end
        end
      end

      ST_ARMED: begin
        if (back || select) begin
          state_d = ST_IDLE;
        end else if (beat_tick) begin
          state_d = ST_RECORD;
          ptr_d   = '0;
        end
      end

      ST_RECORD: begin
        if (back) begin
          length_d = '0;
          state_d  = ST_IDLE;
        end else if (select) begin
          length_d = {1'b0, ptr_q};
          state_d  = ST_IDLE;
        end else if (beat_tick) begin
          // The write itself is the combinational ram_wren above.
          if (ptr_q == LAST_PTR) begin
            length_d = FULL_LEN;
            state_d  = ST_IDLE;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end

      ST_PLAY: begin
        if (back || select) begin
          note_out_d = '0;
          state_d    = ST_IDLE;
        end else if (beat_tick) begin
          state_d = ST_PFETCH;
        end
      end

      ST_PFETCH: begin
        if (back || select) begin
          note_out_d = '0;
          state_d    = ST_IDLE;
        end else begin
          note_out_d   = ram_rdata;
          note_valid_d = 1'b1;
          if (is_last_note) begin
            if (loop) begin
              ptr_d   = '0;
              state_d = ST_PLAY;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = ST_PLAY;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      length_q     <= '0;
      note_out_q   <= '0;
      note_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      length_q     <= length_d;
      note_out_q   <= note_out_d;
      note_valid_q <= note_valid_d;
    end
  end

  assign note_out   = note_out_q;
  assign note_valid = note_valid_q;
  assign length     = length_q;
  assign state      = state_q;

endmodule

// File: tb/tb_record_play_ctrl.sv
// ---------------------------------------------------------------------------
// tb_record_play_ctrl
//   Directed bench for record_play_ctrl with a behavioural synchronous RAM
//   and a log of every RAM write seen on the port.
// ---------------------------------------------------------------------------
module tb_record_play_ctrl;

  import record_play_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          beat_tick;
  logic          select;
  logic          back;
  logic          mode_rec;
  logic          loop;
  logic [DW-1:0] note_in;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] note_out;
  logic          note_valid;
  logic [AW:0]   length;
  logic [2:0]    state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  record_play_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .beat_tick  (beat_tick),
    .select     (select),
    .back       (back),
    .mode_rec   (mode_rec),
    .loop       (loop),
    .note_in    (note_in),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_wren   (ram_wren),
    .ram_wdata  (ram_wdata),
    .note_out   (note_out),
    .note_valid (note_valid),
    .length     (length),
    .state      (state)
  );

  // Synchronous RAM: read data valid one cycle after the address.
  logic [DW-1:0] mem [0:MAX_NOTES-1];
  int            wr_addr_log [$];
  logic [DW-1:0] wr_data_log [$];

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
      wr_addr_log.push_back(int'(ram_addr));
      wr_data_log.push_back(ram_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit after the
  // rising edge, then drop all pulse inputs.
  task automatic cyc(input logic sel, input logic bk, input logic bt, input logic [DW-1:0] ni);
    @(negedge clk);
    select    = sel;
    back      = bk;
    beat_tick = bt;
    note_in   = ni;
    @(posedge clk);
    #1;
    select    = 1'b0;
    back      = 1'b0;
    beat_tick = 1'b0;
    note_in   = '0;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic sel_cyc();
    cyc(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic back_cyc();
    cyc(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic beat_cyc(input logic [DW-1:0] ni);
    cyc(1'b0, 1'b0, 1'b1, ni);
  endtask

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  // One playback beat: fetch state one cycle after the tick, the note and
  // its valid pulse exactly two cycles after, pulse gone on the third.
  task automatic play_beat(input string tag, input logic [DW-1:0] exp_note,
                           input logic [2:0] exp_state);
    beat_cyc('0);
    check({tag, "_pfetch"}, 64'(state), 64'(ST_PFETCH));
    check({tag, "_valid_t1"}, 64'(note_valid), 64'd0);
    idle_cyc();
    check({tag, "_valid_t2"}, 64'(note_valid), 64'd1);
    check({tag, "_note"}, 64'(note_out), 64'(exp_note));
    check({tag, "_state"}, 64'(state), 64'(exp_state));
    idle_cyc();
    check({tag, "_valid_t3"}, 64'(note_valid), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] exp_seq [0:6];
    int            errs;

    reset     = 1'b1;
    beat_tick = 1'b0;
    select    = 1'b0;
    back      = 1'b0;
    mode_rec  = 1'b0;
    loop      = 1'b0;
    note_in   = '0;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_length", 64'(length), 64'd0);
    check("rst_note_out", 64'(note_out), 64'd0);
    check("rst_note_valid", 64'(note_valid), 64'd0);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- play select with nothing stored is ignored
    mode_rec = 1'b0;
    sel_cyc();
    check("empty_play_ignored", 64'(state), 64'(ST_IDLE));

    // ---- two short pulses inside one beat merge into one write of 0x6
    mode_rec = 1'b1;
    clear_log();
    sel_cyc();
    check("arm_state", 64'(state), 64'(ST_ARMED));
    beat_cyc('0);
    check("record_state", 64'(state), 64'(ST_RECORD));
    cyc(1'b0, 1'b0, 1'b0, 32'h2);
    cyc(1'b0, 1'b0, 1'b0, 32'h4);
    idle_cyc();
    beat_cyc('0);
    sel_cyc();
    check("sticky_nwr", 64'(wr_addr_log.size()), 64'd1);
    check("sticky_addr", 64'(wr_addr_log[0]), 64'd0);
    check("sticky_data", 64'(wr_data_log[0]), 64'h6);
    check("sticky_length", 64'(length), 64'd1);

    // ---- three beats, then stop: length 3
    clear_log();
    sel_cyc();
    beat_cyc('0);
    beat_cyc(32'h1);
    idle_cyc();
    beat_cyc(32'h40);
    idle_cyc();
    beat_cyc(32'h1000);
    idle_cyc();
    sel_cyc();
    check("rec3_nwr", 64'(wr_addr_log.size()), 64'd3);
    check("rec3_addr0", 64'(wr_addr_log[0]), 64'd0);
    check("rec3_data0", 64'(wr_data_log[0]), 64'h1);
    check("rec3_addr1", 64'(wr_addr_log[1]), 64'd1);
    check("rec3_data1", 64'(wr_data_log[1]), 64'h40);
    check("rec3_addr2", 64'(wr_addr_log[2]), 64'd2);
    check("rec3_data2", 64'(wr_data_log[2]), 64'h1000);
    check("rec3_length", 64'(length), 64'd3);
    check("rec3_state", 64'(state), 64'(ST_IDLE));

    // ---- looping playback of 3 notes over 7 beats
    mode_rec = 1'b0;
    loop     = 1'b1;
    sel_cyc();
    check("play_state", 64'(state), 64'(ST_PLAY));
    exp_seq[0] = 32'h1;    exp_seq[1] = 32'h40; exp_seq[2] = 32'h1000;
    exp_seq[3] = 32'h1;    exp_seq[4] = 32'h40; exp_seq[5] = 32'h1000;
    exp_seq[6] = 32'h1;
    for (int i = 0; i < 7; i++) begin
      play_beat($sformatf("loop%0d", i), exp_seq[i], ST_PLAY);
      idle_cyc();
    end
    sel_cyc();
    check("play_stop_state", 64'(state), 64'(ST_IDLE));
    check("play_stop_note", 64'(note_out), 64'd0);
    check("play_stop_length", 64'(length), 64'd3);

    // ---- select and beat together at ptr=4: no write, length 4
    mode_rec = 1'b1;
    clear_log();
    sel_cyc();
    beat_cyc('0);
    for (int i = 0; i < 4; i++) begin
      beat_cyc(32'h10 + DW'(i));
      idle_cyc();
    end
    cyc(1'b1, 1'b0, 1'b1, 32'hFF);
    check("selbeat_nwr", 64'(wr_addr_log.size()), 64'd4);
    check("selbeat_length", 64'(length), 64'd4);
    check("selbeat_state", 64'(state), 64'(ST_IDLE));

    // ---- non-looping playback ends in IDLE holding the last note
    mode_rec = 1'b0;
    loop     = 1'b0;
    sel_cyc();
    for (int i = 0; i < 3; i++) begin
      play_beat($sformatf("once%0d", i), 32'h10 + DW'(i), ST_PLAY);
      idle_cyc();
    end
    play_beat("once3", 32'h13, ST_IDLE);
    beat_cyc('0);
    check("once_tick_ignored", 64'(state), 64'(ST_IDLE));
    check("once_note_held", 64'(note_out), 64'h13);

    // ---- back in ARMED keeps length
    mode_rec = 1'b1;
    sel_cyc();
    back_cyc();
    check("armed_back_state", 64'(state), 64'(ST_IDLE));
    check("armed_back_length", 64'(length), 64'd4);

    // ---- back in RECORD after 5 writes discards everything
    clear_log();
    sel_cyc();
    beat_cyc('0);
    for (int i = 0; i < 5; i++) begin
      beat_cyc(32'h20 + DW'(i));
      idle_cyc();
    end
    back_cyc();
    check("abort_nwr", 64'(wr_addr_log.size()), 64'd5);
    check("abort_length", 64'(length), 64'd0);
    check("abort_state", 64'(state), 64'(ST_IDLE));
    mode_rec = 1'b0;
    sel_cyc();
    check("abort_play_ignored", 64'(state), 64'(ST_IDLE));

    // ---- fill all 64 slots: auto-stop, no 65th write
    mode_rec = 1'b1;
    clear_log();
    sel_cyc();
    beat_cyc('0);
    for (int i = 0; i < MAX_NOTES; i++) begin
      beat_cyc(32'h100 + DW'(i));
      if (i == MAX_NOTES - 2) check("full_still_rec", 64'(state), 64'(ST_RECORD));
    end
    check("full_state", 64'(state), 64'(ST_IDLE));
    check("full_length", 64'(length), 64'd64);
    beat_cyc(32'hDEAD);
    check("full_nwr", 64'(wr_addr_log.size()), 64'd64);
    errs = 0;
    for (int i = 0; i < wr_addr_log.size(); i++) begin
      if (wr_addr_log[i] != i || wr_data_log[i] !== 32'h100 + DW'(i)) errs++;
    end
    check("full_contents_errs", 64'(errs), 64'd0);
    if (wr_addr_log.size() == 64) check("full_last_addr", 64'(wr_addr_log[63]), 64'd63);

    // ---- reset mid-record wins over a coinciding beat
    clear_log();
    sel_cyc();
    beat_cyc('0);
    beat_cyc(32'h1);
    beat_cyc(32'h2);
    @(negedge clk);
    reset     = 1'b1;
    beat_tick = 1'b1;
    note_in   = 32'h7;
    #1;
    check("rstrec_wren", 64'(ram_wren), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    beat_tick = 1'b0;
    note_in   = '0;
    check("rstrec_state", 64'(state), 64'(ST_IDLE));
    check("rstrec_length", 64'(length), 64'd0);
    check("rstrec_nwr", 64'(wr_addr_log.size()), 64'd2);
    mode_rec = 1'b0;
    sel_cyc();
    check("rstrec_play_ignored", 64'(state), 64'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
